instr_link_tx: RTL and testbench

Host-side transmitter for the core's 8-bit instruction link. Buffers 16-bit instruction words in a small FIFO and sends each word over the 8-bit link as two acknowledged bytes, high byte first. It then collects the two-byte register readback returned by the core. Sits between test/host logic and the core pins; it is the sending end of the link the core consumes on its instruction inputs.

---
 rtl/instr_link_tx.sv | 189 ++++++++++++++++++
 tb/tb_instr_link_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_link_tx.sv
// Host-side sender for the 8-bit instruction link: queues 16-bit words, sends each
// as two acknowledged bytes (high first), then collects the core's two-byte readback.
module instr_link_tx #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_instr,
    output logic [7:0]                 link_data,
    output logic                       link_hi,
    output logic                       link_valid,
    input  logic                       link_ack,
    input  logic                       resp_valid,
    input  logic [7:0]                 resp_byte,
    output logic                       rd_valid,
    output logic [15:0]                rd_data,
    output logic                       err,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_HI = 3'd1,
        SEND_LO = 3'd2,
        RESP_HI = 3'd3,
        RESP_LO = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     word_q, word_d;
    logic [7:0]      timer_q, timer_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    logic [15:0]     fifo_mem [DEPTH];

    logic            push;
    logic            pop;
    logic            timeout_hit;

    assign in_ready    = (level_q != LW'(DEPTH));
    assign push        = in_valid && in_ready;
    assign pop         = (state_q == IDLE) && (level_q != '0);
    // The awaited event takes priority, so this only matters on a stalled cycle.
    assign timeout_hit = (timer_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_instr;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        timer_d    = timer_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    word_d  = fifo_mem[rd_ptr_q];
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (link_ack) begin
                    state_d = SEND_LO;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            SEND_LO: begin
                if (link_ack) begin
                    state_d = RESP_HI;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            RESP_HI: begin
                if (resp_valid) begin
                    rd_data_d[15:8] = resp_byte;
                    state_d         = RESP_LO;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            RESP_LO: begin
                if (resp_valid) begin
                    rd_data_d[7:0] = resp_byte;
                    rd_valid_d     = 1'b1;
                    state_d        = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q != IDLE) begin
            timer_d = timer_q + 8'd1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            timer_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            timer_q    <= timer_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    always_comb begin
        link_valid = (state_q == SEND_HI) || (state_q == SEND_LO);
        link_hi    = (state_q == SEND_HI);
        link_data  = 8'd0;
        if (state_q == SEND_HI) begin
            link_data = word_q[15:8];
        end else if (state_q == SEND_LO) begin
            link_data = word_q[7:0];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;
    assign level    = level_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_instr_link_tx.sv
// Directed bench for instr_link_tx with DEPTH=4, TIMEOUT=8; expected values hand-derived.
module tb_instr_link_tx;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [7:0]  link_data;
    logic        link_hi;
    logic        link_valid;
    logic        link_ack;
    logic        resp_valid;
    logic [7:0]  resp_byte;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        err;
    logic [2:0]  level;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    instr_link_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .link_data  (link_data),
        .link_hi    (link_hi),
        .link_valid (link_valid),
        .link_ack   (link_ack),
        .resp_valid (resp_valid),
        .resp_byte  (resp_byte),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .err        (err),
        .level      (level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Entered with word w already on the link as the high byte; returns in the IDLE
    // cycle that carries the rd_valid pulse.
    task automatic serve(input logic [15:0] w, input logic [15:0] r, input string tag);
        check({tag, "_hi_valid"}, 32'(link_valid), 32'd1);
        check({tag, "_hi_flag"},  32'(link_hi),    32'd1);
        check({tag, "_hi_data"},  32'(link_data),  32'(w[15:8]));
        link_ack = 1'b1;
        tick();
        check({tag, "_lo_valid"}, 32'(link_valid), 32'd1);
        check({tag, "_lo_flag"},  32'(link_hi),    32'd0);
        check({tag, "_lo_data"},  32'(link_data),  32'(w[7:0]));
        tick();
        link_ack = 1'b0;
        check({tag, "_resp_link_idle"}, 32'(link_valid), 32'd0);
        resp_valid = 1'b1;
        resp_byte  = r[15:8];
        tick();
        check({tag, "_no_early_rd"}, 32'(rd_valid), 32'd0);
        resp_byte = r[7:0];
        tick();
        resp_valid = 1'b0;
        resp_byte  = 8'h00;
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_rd_data"},  32'(rd_data),  32'(r));
        check({tag, "_idle"},     32'(busy),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_instr   = 16'h0000;
        link_ack   = 1'b0;
        resp_valid = 1'b0;
        resp_byte  = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_level",      32'(level),      32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_link_valid", 32'(link_valid), 32'd0);
        check("rst_link_data",  32'(link_data),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_rd_data",    32'(rd_data),    32'd0);

        // Basic transfer
        in_valid = 1'b1;
        in_instr = 16'hA5C3;
        tick();
        in_valid = 1'b0;
        check("basic_level1", 32'(level), 32'd1);
        check("basic_busy0",  32'(busy),  32'd0);
        tick();
        check("basic_popped", 32'(level), 32'd0);
        check("basic_busy1",  32'(busy),  32'd1);
        serve(16'hA5C3, 16'h1234, "basic");
        tick();
        check("basic_single_pulse", 32'(rd_valid), 32'd0);
        check("basic_rd_hold",      32'(rd_data),  32'h1234);

        // Ack delayed 7 cycles; ack arrives on the cycle the timer would expire
        in_valid = 1'b1;
        in_instr = 16'h1111;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("stall%0d_data", i), 32'(link_data), 32'h11);
            check($sformatf("stall%0d_hi", i),   32'(link_hi),   32'd1);
            tick();
        end
        serve(16'h1111, 16'h0001, "stall");
        tick();

        // Fill FIFO while the link is stalled; the sixth word is dropped
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_instr = 16'hA000 + 16'(i);
            tick();
        end
        in_instr = 16'hA005;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level",    32'(level),    32'd4);
        tick();
        in_valid = 1'b0;
        check("full_drop_level", 32'(level), 32'd4);
        for (int i = 0; i < 5; i++) begin
            serve(16'hA000 + 16'(i), 16'hB000 + 16'(i), $sformatf("full%0d", i));
            tick();
        end
        check("full_drained_busy",  32'(busy),       32'd0);
        check("full_drained_level", 32'(level),      32'd0);
        check("full_drained_link",  32'(link_valid), 32'd0);

        // Timeout with no ack; next queued word then goes out normally
        in_valid = 1'b1;
        in_instr = 16'hBEEF;
        tick();
        in_instr = 16'h2222;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            check($sformatf("to%0d_no_err", i), 32'(err),        32'd0);
            check($sformatf("to%0d_valid", i),  32'(link_valid), 32'd1);
            tick();
        end
        check("to_err_pulse",  32'(err),        32'd1);
        check("to_link_drop",  32'(link_valid), 32'd0);
        check("to_busy0",      32'(busy),       32'd0);
        check("to_level",      32'(level),      32'd1);
        tick();
        check("to_err_single", 32'(err),        32'd0);
        serve(16'h2222, 16'h5A5A, "after_to");
        tick();

        // Simultaneous push and pop at level 2, with stray resp_valid outside RESP_*
        in_valid = 1'b1;
        in_instr = 16'hC001;
        tick();
        in_instr = 16'hC002;
        tick();
        in_instr = 16'hC003;
        tick();
        in_valid = 1'b0;
        check("pp_level2", 32'(level), 32'd2);
        serve(16'hC001, 16'h0F0F, "pp0");
        in_valid   = 1'b1;
        in_instr   = 16'hC004;
        resp_valid = 1'b1;
        resp_byte  = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("pp_level_same", 32'(level), 32'd2);
        tick();
        resp_valid = 1'b0;
        resp_byte  = 8'h00;
        check("stray_rd_data",  32'(rd_data),  32'h0F0F);
        check("stray_rd_valid", 32'(rd_valid), 32'd0);
        serve(16'hC002, 16'h1010, "pp1");
        tick();
        serve(16'hC003, 16'h1212, "pp2");
        tick();
        serve(16'hC004, 16'h1313, "pp3");
        tick();
        check("pp_done_busy",  32'(busy),  32'd0);
        check("pp_done_level", 32'(level), 32'd0);

        // Reset during RESP_LO with a word still queued
        in_valid = 1'b1;
        in_instr = 16'h3C3C;
        tick();
        in_instr = 16'h4444;
        tick();
        in_valid = 1'b0;
        link_ack = 1'b1;
        tick();
        tick();
        link_ack   = 1'b0;
        resp_valid = 1'b1;
        resp_byte  = 8'h77;
        tick();
        check("mid_hi_capture", 32'(rd_data), 32'h7713);
        check("mid_level",      32'(level),   32'd1);
        rst       = 1'b1;
        resp_byte = 8'h88;
        tick();
        rst        = 1'b0;
        resp_valid = 1'b0;
        resp_byte  = 8'h00;
        check("mrst_rd_valid",   32'(rd_valid),   32'd0);
        check("mrst_rd_data",    32'(rd_data),    32'd0);
        check("mrst_level",      32'(level),      32'd0);
        check("mrst_busy",       32'(busy),       32'd0);
        check("mrst_link_valid", 32'(link_valid), 32'd0);
        check("mrst_err",        32'(err),        32'd0);
        check("mrst_in_ready",   32'(in_ready),   32'd1);
        tick();
        check("mrst_after_rd_valid", 32'(rd_valid),   32'd0);
        check("mrst_after_link",     32'(link_valid), 32'd0);
        check("mrst_after_busy",     32'(busy),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
